// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder/subtractor.
package bcd_pkg;

   localparam int unsigned BCD_W   = 4;
   localparam int unsigned BCD_MAX = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic logic is_bcd(input logic [BCD_W-1:0] nibble);
      return nibble <= BCD_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_serial_addsub_if.sv
// Start/busy/done handshake and operand/result bus of the serial BCD unit.
interface bcd_serial_addsub_if import bcd_pkg::*; #(
   parameter int unsigned DIGITS = 4
) ();

   localparam int unsigned W = BCD_W * DIGITS;

   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry;
   logic         invalid;

   modport master (
      output start, sub, a, b,
      input  busy, done, sum, carry, invalid
   );

   modport slave (
      input  start, sub, a, b,
      output busy, done, sum, carry, invalid
   );

endinterface

// File: rtl/bcd_digit_adder.sv
// One-digit BCD add/subtract stage; subtract uses the nine's complement of b_d
// so that a carry-in of 1 yields ten's-complement arithmetic.
module bcd_digit_adder import bcd_pkg::*; (
   input  logic [BCD_W-1:0] a_d,
   input  logic [BCD_W-1:0] b_d,
   input  logic             cin,
   input  logic             sub,
   output logic [BCD_W-1:0] d,
   output logic             cout
);

   logic [BCD_W-1:0] b_eff;
   logic [BCD_W:0]   t;

   always_comb begin
      b_eff = sub ? (BCD_W'(BCD_MAX) - b_d) : b_d;
      t     = {1'b0, a_d} + {1'b0, b_eff} + (BCD_W+1)'(cin);
      d     = t[BCD_W-1:0];
      cout  = 1'b0;
      if (t > (BCD_W+1)'(BCD_MAX)) begin
         d    = BCD_W'(t + (BCD_W+1)'(6));
         cout = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one digit per clock, LSD first, with
// start/busy/done handshake and operand validity check at capture.
module bcd_serial_addsub import bcd_pkg::*; #(
   parameter int unsigned DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   bcd_serial_addsub_if.slave  bus
);

   localparam int unsigned W     = BCD_W * DIGITS;
   localparam int unsigned IDX_W = $clog2(DIGITS) + 1;

   state_e             state_q, state_d;
   logic [W-1:0]       opa_q, opa_d;
   logic [W-1:0]       opb_q, opb_d;
   logic [W-1:0]       psum_q, psum_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               c_q, c_d;
   logic               sub_q, sub_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               carry_q, carry_d;
   logic               invalid_q, invalid_d;

   logic               ops_ok_c;
   logic [BCD_W-1:0]   dig_c;
   logic               cout_c;
   logic [W-1:0]       shifted_c;

   bcd_digit_adder u_digit (
      .a_d  (opa_q[BCD_W-1:0]),
      .b_d  (opb_q[BCD_W-1:0]),
      .cin  (c_q),
      .sub  (sub_q),
      .d    (dig_c),
      .cout (cout_c)
   );

   // Every nibble of both operands must be a decimal digit.
   always_comb begin
      ops_ok_c = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (!is_bcd(bus.a[i*BCD_W +: BCD_W]) || !is_bcd(bus.b[i*BCD_W +: BCD_W])) begin
            ops_ok_c = 1'b0;
         end
      end
   end

   // New digit enters at the MSD end; after DIGITS shifts digit 0 sits in [3:0].
   assign shifted_c = W'({dig_c, psum_q} >> BCD_W);

   always_comb begin
      state_d   = state_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      psum_d    = psum_q;
      idx_d     = idx_q;
      c_d       = c_q;
      sub_d     = sub_q;
      err_d     = err_q;
      sum_d     = sum_q;
      carry_d   = carry_q;
      invalid_d = invalid_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               opa_d   = bus.a;
               opb_d   = bus.b;
               sub_d   = bus.sub;
               idx_d   = '0;
               psum_d  = '0;
               c_d     = bus.sub;
               err_d   = ~ops_ok_c;
               state_d = RUN;
            end
         end
         RUN: begin
            // A bad operand spends one RUN cycle so done lands one edge after capture+1.
            if (err_q) begin
               state_d   = DONE;
               sum_d     = '0;
               carry_d   = 1'b0;
               invalid_d = 1'b1;
            end else begin
               opa_d  = opa_q >> BCD_W;
               opb_d  = opb_q >> BCD_W;
               psum_d = shifted_c;
               c_d    = cout_c;
               idx_d  = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(DIGITS - 1)) begin
                  state_d   = DONE;
                  sum_d     = shifted_c;
                  carry_d   = sub_q ? ~cout_c : cout_c;
                  invalid_d = 1'b0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         opa_q     <= '0;
         opb_q     <= '0;
         psum_q    <= '0;
         idx_q     <= '0;
         c_q       <= 1'b0;
         sub_q     <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sum_q     <= '0;
         carry_q   <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         psum_q    <= psum_d;
         idx_q     <= idx_d;
         c_q       <= c_d;
         sub_q     <= sub_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sum_q     <= sum_d;
         carry_q   <= carry_d;
         invalid_q <= invalid_d;
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sum     = sum_q;
   assign bus.carry   = carry_q;
   assign bus.invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench: three instances (1, 4, 8 digits) share operands; a decimal
// integer model predicts each result and per-instance monitors compare on done.
module tb_bcd_serial_addsub;

   typedef struct {
      logic [31:0] sum;
      logic        carry;
      logic        inv;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] a_drv, b_drv;
   logic        sub_drv;
   logic [2:0]  start_v;

   exp_t q1[$], q4[$], q8[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   bcd_serial_addsub_if #(.DIGITS(1)) if1 ();
   bcd_serial_addsub_if #(.DIGITS(4)) if4 ();
   bcd_serial_addsub_if #(.DIGITS(8)) if8 ();

   assign if1.start = start_v[0];
   assign if4.start = start_v[1];
   assign if8.start = start_v[2];
   assign if1.sub   = sub_drv;
   assign if4.sub   = sub_drv;
   assign if8.sub   = sub_drv;
   assign if1.a     = a_drv[3:0];
   assign if1.b     = b_drv[3:0];
   assign if4.a     = a_drv[15:0];
   assign if4.b     = b_drv[15:0];
   assign if8.a     = a_drv;
   assign if8.b     = b_drv;

   bcd_serial_addsub #(.DIGITS(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   bcd_serial_addsub #(.DIGITS(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
   bcd_serial_addsub #(.DIGITS(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   function automatic longint pow10(input int n);
      longint p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Decimal reference: decode to integers, do the arithmetic, re-encode.
   function automatic exp_t model(input int nd, input logic s, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint av = 0, bv = 0, m, r;
      logic [3:0] na, nb;
      m = pow10(nd);
      e.sum = '0; e.carry = 1'b0; e.inv = 1'b0;
      for (int i = nd - 1; i >= 0; i--) begin
         na = a[i*4 +: 4];
         nb = b[i*4 +: 4];
         if (na > 4'd9 || nb > 4'd9) e.inv = 1'b1;
         av = av * 10 + longint'(na);
         bv = bv * 10 + longint'(nb);
      end
      if (e.inv) return e;
      if (s) begin
         e.carry = (av < bv);
         r = (av - bv + m) % m;
      end else begin
         r = av + bv;
         e.carry = (r >= m);
         r = r % m;
      end
      for (int i = 0; i < nd; i++) begin
         e.sum[i*4 +: 4] = 4'(r % 10);
         r = r / 10;
      end
      return e;
   endfunction

   task automatic chk_done(input int k, input logic [31:0] s, input logic c, input logic inv, input logic busy);
      exp_t  e;
      bit    have = 0;
      string n;
      case (k)
         0: begin n = "u1"; if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end end
         1: begin n = "u4"; if (q4.size() > 0) begin e = q4.pop_front(); have = 1; end end
         default: begin n = "u8"; if (q8.size() > 0) begin e = q8.pop_front(); have = 1; end end
      endcase
      if (!have) begin
         fail({n, " unexpected done"});
      end else begin
         check({n, " sum"}, longint'(s), longint'(e.sum));
         check({n, " carry"}, longint'(c), longint'(e.carry));
         check({n, " invalid"}, longint'(inv), longint'(e.inv));
         check({n, " busy at done"}, longint'(busy), 1);
      end
   endtask

   // Monitors: pop and compare whenever an instance presents done.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (if1.done) chk_done(0, 32'(if1.sum), if1.carry, if1.invalid, if1.busy);
         if (if4.done) chk_done(1, 32'(if4.sum), if4.carry, if4.invalid, if4.busy);
         if (if8.done) chk_done(2, if8.sum, if8.carry, if8.invalid, if8.busy);
      end
   end

   task automatic run_op(input logic [2:0] mask, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input int restart_at = 0);
      exp_t e4;
      int   busy4 = 0, done4 = 0;
      bit   ok = 0;
      a_drv = a; b_drv = b; sub_drv = s;
      e4 = model(4, s, a, b);
      if (mask[0]) q1.push_back(model(1, s, a, b));
      if (mask[1]) q4.push_back(e4);
      if (mask[2]) q8.push_back(model(8, s, a, b));
      start_v = mask;
      @(posedge clk);
      #1;
      start_v = '0;
      a_drv   = $urandom;
      b_drv   = $urandom;
      sub_drv = 1'($urandom);
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (if4.busy) busy4++;
         if (if4.done) done4++;
         start_v[1] = (j == restart_at);
         if (!if1.busy && !if4.busy && !if8.busy && start_v == '0) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail("operation timeout");
      if (mask[1]) begin
         check("u4 busy cycles", busy4, e4.inv ? 2 : 5);
         check("u4 done pulses", done4, 1);
      end
   endtask

   task automatic reset_mid_run();
      int done4 = 0;
      q4.push_back(model(4, 1'b0, 32'h0062, 32'h0059));
      a_drv = 32'h0062; b_drv = 32'h0059; sub_drv = 1'b0;
      start_v = 3'b010;
      @(posedge clk);
      #1 start_v = '0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q4.delete();
      @(negedge clk);
      check("rst busy", longint'(if4.busy), 0);
      check("rst done", longint'(if4.done), 0);
      check("rst sum", longint'(if4.sum), 0);
      check("rst carry", longint'(if4.carry), 0);
      check("rst invalid", longint'(if4.invalid), 0);
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         if (if4.done) done4++;
      end
      check("no done after rst", done4, 0);
   endtask

   function automatic logic [31:0] rand_bcd();
      logic [31:0] v;
      for (int i = 0; i < 8; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      int          pos;
      rst = 1'b1; start_v = '0; a_drv = '0; b_drv = '0; sub_drv = 1'b0;
      repeat (3) @(posedge clk);
      // start asserted together with rst must be ignored
      a_drv = 32'h0011; b_drv = 32'h0022; start_v = 3'b111;
      @(posedge clk);
      #1 rst = 1'b0; start_v = '0;
      @(negedge clk);
      check("reset u4 busy", longint'(if4.busy), 0);
      check("reset u4 done", longint'(if4.done), 0);
      check("reset u4 sum", longint'(if4.sum), 0);
      check("reset u4 carry", longint'(if4.carry), 0);
      check("reset u4 invalid", longint'(if4.invalid), 0);
      check("reset u1 sum", longint'(if1.sum), 0);
      check("reset u8 sum", longint'(if8.sum), 0);
      check("reset u8 busy", longint'(if8.busy), 0);

      run_op(3'b010, 1'b0, 32'h0062, 32'h0059);
      run_op(3'b010, 1'b0, 32'h9999, 32'h0001);
      run_op(3'b010, 1'b0, 32'h5000, 32'h5000);
      run_op(3'b010, 1'b1, 32'h0043, 32'h0035);
      run_op(3'b010, 1'b1, 32'h0029, 32'h0062);
      run_op(3'b010, 1'b1, 32'h1234, 32'h1234);
      run_op(3'b010, 1'b0, 32'h00B5, 32'h0001);
      run_op(3'b010, 1'b0, 32'h0001, 32'h0001);
      run_op(3'b010, 1'b0, 32'h0062, 32'h0059, 2);
      run_op(3'b001, 1'b0, 32'h0009, 32'h0009);
      run_op(3'b100, 1'b1, 32'h00000001, 32'h99999999);
      reset_mid_run();
      run_op(3'b010, 1'b0, 32'h0062, 32'h0059);

      for (int n = 0; n < 60; n++) begin
         ra = rand_bcd();
         rb = rand_bcd();
         if ($urandom_range(0, 5) == 0) begin
            pos = $urandom_range(0, 7);
            ra[pos*4 +: 4] = 4'($urandom_range(10, 15));
         end
         run_op(3'b111, 1'($urandom), ra, rb);
      end

      repeat (5) @(negedge clk);
      check("leftover u1", q1.size(), 0);
      check("leftover u4", q4.size(), 0);
      check("leftover u8", q8.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
